fir_decim_mc: RTL and testbench

FIR_DECIM_MC -- requirements
Module: fir_decim_mc

---
 rtl/fir_pkg.sv | 43 ++++
 rtl/fir_mac.sv | 34 +++
 rtl/fir_decim_mc.sv | 172 +++++++++++++++++
 tb/tb_fir_decim_mc.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FSM encoding, accumulator sizing and the round/saturate helpers
// used by fir_decim_mc; widths are passed in so one package serves any size.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

  // Wide working width for rounding, so adding the rounding bias never wraps
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // ACC_W: room for TAPS full-scale products without wrap
  function automatic int acc_w(int data_w, int coef_w, int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Round half up, then arithmetic shift right
  function automatic wide_t round_shift(wide_t v, int sh);
    wide_t half;
    half = '0;
    if (sh > 0)
      half = wide_t'(1) <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  // Clamp to the signed range of a w-bit value
  function automatic wide_t saturate(wide_t v, int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi)
      return hi;
    if (v < lo)
      return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate: clr zeroes the accumulator, en adds a*b.
// Ports: clk, rst (async high), clr, en, a, b -> acc.
module fir_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_x;

  assign prod   = P_W'(a) * P_W'(b);
  assign prod_x = {{(ACC_W - P_W){prod[P_W-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + prod_x;
  end

endmodule

// File: rtl/fir_decim_mc.sv
// Multichannel decimating FIR, one MAC per cycle, shared coefficient bank.
// Ports: aclk/areset, coef write port, enable, AXI-S in/out, sticky errors.
module fir_decim_mc
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 53,
  parameter int CHANNELS  = 2,
  parameter int DECIM     = 1,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]  coef_wr_addr,
  input  logic [COEF_W-1:0]        coef_wr_data,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     coef_err,
  output logic                     frame_err
);

  localparam int AW    = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(DECIM - 1);
  localparam logic [AW-1:0]   LAST_K  = AW'(TAPS - 1);

  state_t state, nxt;

  logic [CH_W-1:0] ch, out_ch;
  logic [PH_W-1:0] phase;
  logic [AW-1:0]   k;

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] dl   [CHANNELS][TAPS];

  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;

  logic hs, last_ch, mac_clr, mac_en, wr_ok;

  // tready gated by reset so every output reads 0 while areset is high
  assign s_axis_tready = (state == IDLE) & enable & ~areset;
  assign m_axis_tvalid = (state == OUT);
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign last_ch       = (ch == LAST_CH);
  assign wr_ok         = ~enable & (int'(coef_wr_addr) < TAPS);

  assign mac_a = coef[k];
  assign mac_b = dl[out_ch][k];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs && phase == '0) begin
          nxt     = MAC;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k == LAST_K)
          nxt = ROUND;
      end
      ROUND: nxt = OUT;
      OUT: begin
        if (m_axis_tready)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  fir_mac #(
    .A_W  (COEF_W),
    .B_W  (DATA_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk(aclk),
    .rst(areset),
    .clr(mac_clr),
    .en (mac_en),
    .a  (mac_a),
    .b  (mac_b),
    .acc(acc)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < TAPS; i++)
        coef[i] <= '0;
    end else if (coef_wr_en && wr_ok) begin
      coef[coef_wr_addr] <= coef_wr_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < TAPS; i++)
          dl[c][i] <= '0;
    end else if (hs) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (CH_W'(c) == ch) begin
          dl[c][0] <= s_axis_tdata;
          for (int i = 1; i < TAPS; i++)
            dl[c][i] <= dl[c][i-1];
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ch           <= '0;
      out_ch       <= '0;
      phase        <= '0;
      k            <= '0;
      coef_err     <= 1'b0;
      frame_err    <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      if (coef_wr_en && !wr_ok)
        coef_err <= 1'b1;
      if (hs) begin
        out_ch <= ch;
        k      <= '0;
        if (s_axis_tlast != last_ch)
          frame_err <= 1'b1;
        // early tlast realigns the channel counter to the frame
        if (last_ch || s_axis_tlast)
          ch <= '0;
        else
          ch <= ch + 1'b1;
        if (last_ch)
          phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
      end
      if (state == MAC)
        k <= k + 1'b1;
      if (state == ROUND) begin
        m_axis_tdata <= DATA_W'(saturate(
          round_shift(wide_t'(acc), OUT_SHIFT), DATA_W));
        m_axis_tlast <= (out_ch == LAST_CH);
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Directed bench for fir_decim_mc: three configurations (impulse/sat,
// two-channel, decimating with rounding) driven from a vector table.
module tb_fir_decim_mc;

  logic clk;

  logic        rst [3];
  logic        en  [3];
  logic        cwe [3];
  logic [2:0]  cwa [3];
  logic [15:0] cwd [3];
  logic [15:0] sd  [3];
  logic        sv  [3];
  logic        sl  [3];
  logic        mr  [3];
  logic        sr  [3];
  logic [15:0] md  [3];
  logic        mv  [3];
  logic        ml  [3];
  logic        cerr[3];
  logic        ferr[3];

  typedef struct {
    int          d;
    logic [15:0] x;
    logic        xl;
    logic        e;
    int          y;
    logic        yl;
  } vec_t;

  vec_t tv[$];
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];

  int total  = 0;
  int passed = 0;

  fir_decim_mc #(
    .DATA_W(16), .COEF_W(16), .TAPS(5),
    .CHANNELS(1), .DECIM(1), .OUT_SHIFT(0)
  ) u_a (
    .aclk(clk), .areset(rst[0]),
    .coef_wr_en(cwe[0]), .coef_wr_addr(cwa[0]),
    .coef_wr_data(cwd[0]), .enable(en[0]),
    .s_axis_tdata(sd[0]), .s_axis_tvalid(sv[0]),
    .s_axis_tready(sr[0]), .s_axis_tlast(sl[0]),
    .m_axis_tdata(md[0]), .m_axis_tvalid(mv[0]),
    .m_axis_tready(mr[0]), .m_axis_tlast(ml[0]),
    .coef_err(cerr[0]), .frame_err(ferr[0])
  );

  fir_decim_mc #(
    .DATA_W(16), .COEF_W(16), .TAPS(4),
    .CHANNELS(2), .DECIM(1), .OUT_SHIFT(0)
  ) u_b (
    .aclk(clk), .areset(rst[1]),
    .coef_wr_en(cwe[1]), .coef_wr_addr(cwa[1][1:0]),
    .coef_wr_data(cwd[1]), .enable(en[1]),
    .s_axis_tdata(sd[1]), .s_axis_tvalid(sv[1]),
    .s_axis_tready(sr[1]), .s_axis_tlast(sl[1]),
    .m_axis_tdata(md[1]), .m_axis_tvalid(mv[1]),
    .m_axis_tready(mr[1]), .m_axis_tlast(ml[1]),
    .coef_err(cerr[1]), .frame_err(ferr[1])
  );

  fir_decim_mc #(
    .DATA_W(16), .COEF_W(16), .TAPS(4),
    .CHANNELS(1), .DECIM(4), .OUT_SHIFT(2)
  ) u_c (
    .aclk(clk), .areset(rst[2]),
    .coef_wr_en(cwe[2]), .coef_wr_addr(cwa[2][1:0]),
    .coef_wr_data(cwd[2]), .enable(en[2]),
    .s_axis_tdata(sd[2]), .s_axis_tvalid(sv[2]),
    .s_axis_tready(sr[2]), .s_axis_tlast(sl[2]),
    .m_axis_tdata(md[2]), .m_axis_tvalid(mv[2]),
    .m_axis_tready(mr[2]), .m_axis_tlast(ml[2]),
    .coef_err(cerr[2]), .frame_err(ferr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mv[0] && mr[0]) q0.push_back({ml[0], md[0]});
    if (mv[1] && mr[1]) q1.push_back({ml[1], md[1]});
    if (mv[2] && mr[2]) q2.push_back({ml[2], md[2]});
  end

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [16:0] qpop(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void add(int d, int x, bit xl,
                              bit e, int y, bit yl);
    vec_t r;
    r.d  = d;
    r.x  = 16'(x);
    r.xl = xl;
    r.e  = e;
    r.y  = y;
    r.yl = yl;
    tv.push_back(r);
  endfunction

  task automatic wcoef(int d, int a, int v);
    @(posedge clk); #1;
    cwe[d] = 1'b1;
    cwa[d] = 3'(a);
    cwd[d] = 16'(v);
    @(posedge clk); #1;
    cwe[d] = 1'b0;
  endtask

  task automatic send(int d, logic [15:0] x, logic l);
    int n;
    n = 0;
    @(posedge clk); #1;
    sd[d] = x;
    sl[d] = l;
    sv[d] = 1'b1;
    @(negedge clk);
    while (!sr[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sr[d])
      chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    sv[d] = 1'b0;
  endtask

  task automatic get(int d, output logic [16:0] v, output bit ok);
    int n;
    n = 0;
    while (qsize(d) == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (qsize(d) != 0);
    v  = ok ? qpop(d) : 17'h0;
  endtask

  task automatic run_table(string nm);
    logic [16:0] v;
    bit          ok;
    foreach (tv[i]) begin
      send(tv[i].d, tv[i].x, tv[i].xl);
      if (tv[i].e) begin
        get(tv[i].d, v, ok);
        if (!ok) begin
          chk({nm, "_timeout"}, 0, 1);
        end else begin
          chk({nm, "_data"}, longint'($signed(v[15:0])), tv[i].y);
          chk({nm, "_last"}, v[16], tv[i].yl);
        end
      end
    end
    tv.delete();
  endtask

  initial begin
    int          lat;
    int          seen;
    int          n0;
    bit          stable;
    bit          ok;
    logic [16:0] v;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; en[d] = 1'b1; cwe[d] = 1'b0;
      cwa[d] = '0;   cwd[d] = '0;  sd[d]  = '0;
      sv[d]  = 1'b0; sl[d]  = 1'b0; mr[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_tvalid", mv[d], 0);
      chk("rst_tready", sr[d], 0);
      chk("rst_tdata", md[d], 0);
      chk("rst_tlast", ml[d], 0);
      chk("rst_coef_err", cerr[d], 0);
      chk("rst_frame_err", ferr[d], 0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // impulse response, coefs 1..5
    en[0] = 1'b0;
    for (int i = 0; i < 5; i++) wcoef(0, i, i + 1);
    en[0] = 1'b1;
    add(0, 1, 1, 1, 1, 1);
    add(0, 0, 1, 1, 2, 1);
    add(0, 0, 1, 1, 3, 1);
    add(0, 0, 1, 1, 4, 1);
    add(0, 0, 1, 1, 5, 1);
    add(0, 0, 1, 1, 0, 1);
    run_table("impulse");

    // write while running is rejected; bank keeps coef0 = 1
    wcoef(0, 0, 50);
    @(negedge clk);
    chk("coef_err_set", cerr[0], 1);
    add(0, 1, 1, 1, 1, 1);
    add(0, 0, 1, 1, 2, 1);
    add(0, 0, 1, 1, 3, 1);
    add(0, 0, 1, 1, 4, 1);
    add(0, 0, 1, 1, 5, 1);
    run_table("bank_kept");

    // latency and hold under back-pressure
    @(posedge clk); #1;
    mr[0] = 1'b0;
    sd[0] = 16'd7; sl[0] = 1'b1; sv[0] = 1'b1;
    n0 = 0;
    @(negedge clk);
    while (!sr[0] && n0 < 50) begin @(negedge clk); n0++; end
    @(posedge clk); #1;
    sv[0] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mv[0] && lat < 60);
    chk("latency", lat, 7);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (md[0] != 16'd7 || !mv[0] || sr[0] || !ml[0]) stable = 1'b0;
      @(negedge clk);
    end
    chk("hold_stable", stable, 1);
    @(posedge clk); #1;
    mr[0] = 1'b1;
    get(0, v, ok);
    chk("hold_data", ok ? longint'($signed(v[15:0])) : -1, 7);
    @(negedge clk);
    @(negedge clk);
    chk("after_out_tvalid", mv[0], 0);
    chk("after_out_tready", sr[0], 1);

    // saturation both ways
    en[0] = 1'b0;
    for (int i = 0; i < 5; i++) wcoef(0, i, 32'h7FFF);
    en[0] = 1'b1;
    for (int i = 0; i < 5; i++) add(0, 32'h7FFF, 1, 1, 32767, 1);
    add(0, -32767, 1, 1, 32767, 1);
    add(0, -32767, 1, 1, 32767, 1);
    add(0, -32767, 1, 1, -32768, 1);
    add(0, -32767, 1, 1, -32768, 1);
    add(0, -32767, 1, 1, -32768, 1);
    run_table("sat");

    // reset during MAC: nothing delivered, flags and coefs cleared
    n0 = q0.size();
    send(0, 16'd100, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rst_mac_tvalid", mv[0], 0);
    chk("rst_mac_tready", sr[0], 0);
    chk("rst_mac_coef_err", cerr[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (mv[0]) seen++;
    end
    chk("rst_no_output", seen, 0);
    chk("rst_queue", q0.size(), n0);
    chk("rst_frame_err", ferr[0], 0);
    add(0, 9, 1, 1, 0, 1);
    run_table("rst_coefs_zero");

    // two interleaved channels, coefs all 1
    en[1] = 1'b0;
    for (int i = 0; i < 4; i++) wcoef(1, i, 1);
    en[1] = 1'b1;
    for (int r = 0; r < 5; r++) begin
      add(1, 100, 0, 1, 100 * ((r < 3) ? r + 1 : 4), 0);
      add(1, -100, 1, 1, -100 * ((r < 3) ? r + 1 : 4), 1);
    end
    run_table("two_ch");
    chk("frame_err_clean", ferr[1], 0);
    // early tlast on ch0 flags error and realigns to ch0
    add(1, 100, 1, 1, 400, 0);
    add(1, 100, 0, 1, 400, 0);
    run_table("early_tlast");
    @(negedge clk);
    chk("frame_err_set", ferr[1], 1);

    // decimate by 4, y = round((4x[n] + x[n-1]) / 4)
    en[2] = 1'b0;
    wcoef(2, 0, 4);
    wcoef(2, 1, 1);
    en[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       add(2, 0, 1, 1, 0, 1);
        4:       add(2, 40, 1, 1, 48, 1);
        8:       add(2, 80, 1, 1, 98, 1);
        12:      add(2, 120, 1, 1, 148, 1);
        default: add(2, i * 10, 1, 0, 0, 0);
      endcase
    end
    run_table("decim");
    repeat (20) @(negedge clk);
    chk("decim_no_extra", q2.size(), 0);
    chk("decim_frame_err", ferr[2], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
